acc_ctrl_param: RTL and testbench
=================================

ACC_CTRL_PARAM -- requirements
Module: acc_ctrl_param

Interface
REQ-001 The block SHALL expose parameter OPW, default 4, opcode width in bits (minimum 4).
REQ-002 The block SHALL expose parameter ALUW, default 3, ALU operation select width.
REQ-003 The block SHALL expose parameter TMO, default 15, maximum memory wait cycles before bus-error trap (1..255).
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 opcode  input  OPW  instruction opcode from IR.
REQ-007 zero  input  1  accumulator-equals-zero flag.
REQ-008 mem_ack  input  1  memory transfer complete, sampled on clk.
REQ-009 mem_req, mem_we  output  1 each  memory request / write qualifier.
REQ-010 ld_ir, ld_mdr, ld_acc, pc_write  output  1 each  register load strobes.
REQ-011 acc_src, iord, a_src, pc_src  output  1 each  datapath mux selects (acc_src 1=MDR; iord 1=data address; a_src 1=ACC, 0=PC; pc_src 1=IR address field).
REQ-012 b_src  output  2  ALU B select: 00 MDR, 01 constant 1.
REQ-013 alu_op  output  ALUW  ALU op: 0 ADD, 1 SUB, 2 AND, 3 NOT, 4 OR, 5 XOR.
REQ-014 halted, trap  output  1 each  status; state  output  3  current state code (debug).

Function
REQ-015 States SHALL be IF=0, ID=1, EX=2, MEM=3, BR=4, HALT=5, TRAP=6; code 7 SHALL go to TRAP.
REQ-016 Opcode map SHALL be 0 ADD, 1 SUB, 2 AND, 3 NOT, 4 LDA, 5 STA, 6 JMP, 7 JZ, 8 OR, 9 XOR, 10 JNZ, 11 HLT; all other values illegal.
REQ-017 All outputs SHALL default to 0 in every state unless listed below.
REQ-018 IF: mem_req=1, iord=0, a_src=0, b_src=01, alu_op=ADD, pc_src=0; ld_ir and pc_write SHALL equal mem_ack; on mem_ack go to ID, else stay.
REQ-019 ID: decode only, one cycle; ADD/SUB/AND/OR/XOR/LDA go MEM (read), STA goes MEM (write), NOT goes EX, JMP/JZ/JNZ go BR, HLT goes HALT, illegal goes TRAP.
REQ-020 MEM read: mem_req=1, iord=1, ld_mdr=mem_ack; on mem_ack go EX, else stay.
REQ-021 MEM write (STA): mem_req=1, mem_we=1, iord=1; on mem_ack go IF, else stay.
REQ-022 EX: one cycle, ld_acc=1; LDA sets acc_src=1; ALU ops set acc_src=0, a_src=1, b_src=00, alu_op per REQ-013; next state IF.
REQ-023 BR: one cycle, pc_src=1; pc_write=1 for JMP, for JZ iff zero=1, for JNZ iff zero=0; next state IF.
REQ-024 HALT: halted=1, absorbing until reset; TRAP: trap=1, absorbing until reset.
REQ-025 A wait counter SHALL clear on entry to IF or MEM and increment each cycle mem_ack=0 there; reaching TMO with mem_ack=0 SHALL go to TRAP next cycle.
REQ-026 mem_ack in the same cycle the counter reaches TMO SHALL complete the transfer (ack wins).
REQ-027 mem_ack outside IF/MEM SHALL be ignored.
REQ-028 opcode SHALL be sampled only in ID; it is held by IR through EX/MEM/BR (latched copy of instruction class in ID is permitted).

Reset
REQ-029 rst=1 SHALL force state IF, wait counter 0, latched class 0 immediately, independent of clk.
REQ-030 During and after reset, outputs SHALL reflect IF (mem_req=1, iord=0, b_src=01, others 0, ld_ir/pc_write gated by mem_ack).
REQ-031 Reset asserted mid-MEM write SHALL drop mem_we asynchronously.

Structure
REQ-032 State codes, opcode constants and alu_op constants SHALL live in shared package acc_ctrl_pkg.
REQ-033 The wait counter/timeout SHALL be a sub-module mem_wait_timer (params TMO; ports clk, rst, clr, en, expired).

Verification
REQ-034 ADD, mem_ack immediate: IF(ack)->ID->MEM(ack)->EX, 4 cycles; EX shows ld_acc=1, alu_op=0, a_src=1, b_src=00.
REQ-035 STA with 3 wait cycles: MEM holds mem_we=1 for 4 cycles, returns IF on 4th; no ld_acc.
REQ-036 JZ with zero=1 -> BR pc_write=1 pc_src=1; zero=0 -> pc_write=0; JNZ inverse.
REQ-037 mem_ack never in IF with TMO=15: TRAP after 16 cycles, trap=1 held; ack on 16th cycle instead -> ID.
REQ-038 Opcode 12 -> TRAP after ID; opcode 11 -> halted=1 and stays for 20 cycles ignoring mem_ack.
REQ-039 rst pulse mid-EX and mid-MEM write: state=0 and mem_we=0 before next clk edge.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared constants and types for the accumulator controller: state codes,
// opcode map, ALU op codes and the instruction class latched in decode.
package acc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_BR   = 3'd4,
      S_HALT = 3'd5,
      S_TRAP = 3'd6
   } state_t;

   localparam int unsigned OP_ADD = 0;
   localparam int unsigned OP_SUB = 1;
   localparam int unsigned OP_AND = 2;
   localparam int unsigned OP_NOT = 3;
   localparam int unsigned OP_LDA = 4;
   localparam int unsigned OP_STA = 5;
   localparam int unsigned OP_JMP = 6;
   localparam int unsigned OP_JZ  = 7;
   localparam int unsigned OP_OR  = 8;
   localparam int unsigned OP_XOR = 9;
   localparam int unsigned OP_JNZ = 10;
   localparam int unsigned OP_HLT = 11;

   localparam int unsigned ALU_ADD = 0;
   localparam int unsigned ALU_SUB = 1;
   localparam int unsigned ALU_AND = 2;
   localparam int unsigned ALU_NOT = 3;
   localparam int unsigned ALU_OR  = 4;
   localparam int unsigned ALU_XOR = 5;

   localparam int unsigned ALU_CW = 3;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [3:0] {
      C_NONE = 4'd0,
      C_ALU  = 4'd1,
      C_NOT  = 4'd2,
      C_LDA  = 4'd3,
      C_STA  = 4'd4,
      C_JMP  = 4'd5,
      C_JZ   = 4'd6,
      C_JNZ  = 4'd7,
      C_HLT  = 4'd8,
      C_ILL  = 4'd9
   } cls_t;

   typedef struct packed {
      cls_t              cls;
      logic [ALU_CW-1:0] alu;
   } dec_t;

   // Map the low opcode nibble to an instruction class and ALU operation.
   function automatic dec_t decode(input logic [3:0] op);
      dec_t d;
      d.cls = C_ILL;
      d.alu = ALU_CW'(ALU_ADD);
      case (op)
         4'(OP_ADD): begin d.cls = C_ALU; d.alu = ALU_CW'(ALU_ADD); end
         4'(OP_SUB): begin d.cls = C_ALU; d.alu = ALU_CW'(ALU_SUB); end
         4'(OP_AND): begin d.cls = C_ALU; d.alu = ALU_CW'(ALU_AND); end
         4'(OP_NOT): begin d.cls = C_NOT; d.alu = ALU_CW'(ALU_NOT); end
         4'(OP_OR):  begin d.cls = C_ALU; d.alu = ALU_CW'(ALU_OR);  end
         4'(OP_XOR): begin d.cls = C_ALU; d.alu = ALU_CW'(ALU_XOR); end
         4'(OP_LDA): d.cls = C_LDA;
         4'(OP_STA): d.cls = C_STA;
         4'(OP_JMP): d.cls = C_JMP;
         4'(OP_JZ):  d.cls = C_JZ;
         4'(OP_JNZ): d.cls = C_JNZ;
         4'(OP_HLT): d.cls = C_HLT;
         default:    d.cls = C_ILL;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags when TMO is reached.
module mem_wait_timer
   import acc_ctrl_pkg::*;
#(
   parameter int unsigned TMO = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   // Saturates at TMO so a lingering enable cannot wrap the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = (cnt == CNT_W'(TMO));

endmodule

// File: rtl/acc_ctrl_param.sv
// Multi-cycle accumulator CPU control FSM with memory wait timeout trap.
module acc_ctrl_param
   import acc_ctrl_pkg::*;
#(
   parameter int unsigned OPW  = 4,
   parameter int unsigned ALUW = 3,
   parameter int unsigned TMO  = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OPW-1:0]  opcode,
   input  logic            zero,
   input  logic            mem_ack,
   output logic            mem_req,
   output logic            mem_we,
   output logic            ld_ir,
   output logic            ld_mdr,
   output logic            ld_acc,
   output logic            pc_write,
   output logic            acc_src,
   output logic            iord,
   output logic            a_src,
   output logic            pc_src,
   output logic [1:0]      b_src,
   output logic [ALUW-1:0] alu_op,
   output logic            halted,
   output logic            trap,
   output logic [2:0]      state
);

   state_t st_q, st_d;
   dec_t   dec_q, dec_id;
   logic   op_ok, tmr_clr, tmr_en, expired;

   // Opcodes wider than the nibble map are illegal unless upper bits are zero.
   assign op_ok = ((opcode >> 4) == '0);

   always_comb begin
      dec_id = decode(opcode[3:0]);
      if (!op_ok) dec_id.cls = C_ILL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q  <= S_IF;
         dec_q <= '0;
      end else begin
         st_q <= st_d;
         if (st_q == S_ID) dec_q <= dec_id;
      end
   end

   mem_wait_timer #(.TMO(TMO)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (expired)
   );

   always_comb begin
      st_d     = st_q;
      tmr_clr  = 1'b1;
      tmr_en   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ld_ir    = 1'b0;
      ld_mdr   = 1'b0;
      ld_acc   = 1'b0;
      pc_write = 1'b0;
      acc_src  = 1'b0;
      iord     = 1'b0;
      a_src    = 1'b0;
      pc_src   = 1'b0;
      b_src    = 2'b00;
      alu_op   = '0;
      halted   = 1'b0;
      trap     = 1'b0;

      case (st_q)
         S_IF: begin
            mem_req  = 1'b1;
            b_src    = 2'b01;
            alu_op   = ALUW'(ALU_ADD);
            ld_ir    = mem_ack;
            pc_write = mem_ack;
            tmr_clr  = mem_ack;
            tmr_en   = !mem_ack;
            if (mem_ack)      st_d = S_ID;
            else if (expired) st_d = S_TRAP;
         end

         S_ID: begin
            case (dec_id.cls)
               C_ALU, C_LDA, C_STA: st_d = S_MEM;
               C_NOT:               st_d = S_EX;
               C_JMP, C_JZ, C_JNZ:  st_d = S_BR;
               C_HLT:               st_d = S_HALT;
               default:             st_d = S_TRAP;
            endcase
         end

         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            tmr_clr = mem_ack;
            tmr_en  = !mem_ack;
            if (dec_q.cls == C_STA) mem_we = 1'b1;
            else                    ld_mdr = mem_ack;
            if (mem_ack)      st_d = (dec_q.cls == C_STA) ? S_IF : S_EX;
            else if (expired) st_d = S_TRAP;
         end

         S_EX: begin
            ld_acc = 1'b1;
            if (dec_q.cls == C_LDA) begin
               acc_src = 1'b1;
            end else begin
               a_src  = 1'b1;
               alu_op = ALUW'(dec_q.alu);
            end
            st_d = S_IF;
         end

         S_BR: begin
            pc_src   = 1'b1;
            pc_write = (dec_q.cls == C_JMP) ||
                       ((dec_q.cls == C_JZ)  &&  zero) ||
                       ((dec_q.cls == C_JNZ) && !zero);
            st_d     = S_IF;
         end

         S_HALT: halted = 1'b1;

         S_TRAP: trap = 1'b1;

         default: st_d = S_TRAP;
      endcase
   end

   assign state = st_q;

endmodule

// File: tb/tb_acc_ctrl_param.sv
// Scoreboard bench for acc_ctrl_param: per-instruction reference expands each
// instruction into its expected cycle-by-cycle control outputs.
module tb_acc_ctrl_param;

   typedef struct packed {
      logic       mem_req, mem_we, ld_ir, ld_mdr, ld_acc, pc_write;
      logic       acc_src, iord, a_src, pc_src;
      logic [1:0] b_src;
      logic [2:0] alu_op;
      logic       halted, trap;
      logic [2:0] state;
   } ov_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'd0;
   logic       zero = 1'b0;
   logic       mem_ack = 1'b0;
   logic       mem_req, mem_we, ld_ir, ld_mdr, ld_acc, pc_write;
   logic       acc_src, iord, a_src, pc_src, halted, trap;
   logic [1:0] b_src;
   logic [2:0] alu_op;
   logic [2:0] state;
   ov_t        act;

   ov_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   bit  done  = 1'b0;

   acc_ctrl_param #(.OPW(4), .ALUW(3), .TMO(15)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .ld_ir(ld_ir), .ld_mdr(ld_mdr),
      .ld_acc(ld_acc), .pc_write(pc_write), .acc_src(acc_src), .iord(iord),
      .a_src(a_src), .pc_src(pc_src), .b_src(b_src), .alu_op(alu_op),
      .halted(halted), .trap(trap), .state(state)
   );

   always #5 clk = ~clk;

   assign act = {mem_req, mem_we, ld_ir, ld_mdr, ld_acc, pc_write, acc_src,
                 iord, a_src, pc_src, b_src, alu_op, halted, trap, state};

   // Reference: expected outputs for each phase of an instruction.
   function automatic ov_t e_if(input bit a);
      ov_t e = '0;
      e.mem_req = 1'b1; e.b_src = 2'b01; e.ld_ir = a; e.pc_write = a;
      e.state = 3'd0;
      return e;
   endfunction

   function automatic ov_t e_id();
      ov_t e = '0;
      e.state = 3'd1;
      return e;
   endfunction

   function automatic ov_t e_mr(input bit a);
      ov_t e = '0;
      e.mem_req = 1'b1; e.iord = 1'b1; e.ld_mdr = a; e.state = 3'd3;
      return e;
   endfunction

   function automatic ov_t e_mw();
      ov_t e = '0;
      e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1; e.state = 3'd3;
      return e;
   endfunction

   function automatic logic [2:0] alu_of(input logic [3:0] op);
      case (op)
         4'd1:    return 3'd1;
         4'd2:    return 3'd2;
         4'd3:    return 3'd3;
         4'd8:    return 3'd4;
         4'd9:    return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic ov_t e_ex(input logic [3:0] op);
      ov_t e = '0;
      e.ld_acc = 1'b1; e.state = 3'd2;
      if (op == 4'd4) e.acc_src = 1'b1;
      else begin e.a_src = 1'b1; e.alu_op = alu_of(op); end
      return e;
   endfunction

   function automatic ov_t e_br(input logic [3:0] op, input bit z);
      ov_t e = '0;
      e.pc_src = 1'b1; e.state = 3'd4;
      e.pc_write = (op == 4'd6) || (op == 4'd7 && z) || (op == 4'd10 && !z);
      return e;
   endfunction

   function automatic ov_t e_halt();
      ov_t e = '0;
      e.halted = 1'b1; e.state = 3'd5;
      return e;
   endfunction

   function automatic ov_t e_trap();
      ov_t e = '0;
      e.trap = 1'b1; e.state = 3'd6;
      return e;
   endfunction

   function automatic bit is_mem(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9};
   endfunction
   function automatic bit is_ex(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};
   endfunction
   function automatic bit is_br(input logic [3:0] op);
      return op inside {4'd6, 4'd7, 4'd10};
   endfunction

   function automatic bit rz();
      return 1'($urandom);
   endfunction
   function automatic logic [3:0] rop();
      return 4'($urandom);
   endfunction

   // Drive one cycle of inputs and queue the expected outputs for that cycle.
   task automatic cyc_r(input bit r, input bit a, input logic [3:0] op,
                        input bit z, input ov_t e);
      @(posedge clk); #1;
      rst = r; mem_ack = a; opcode = op; zero = z;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input bit a, input logic [3:0] op, input bit z, input ov_t e);
      cyc_r(1'b0, a, op, z, e);
   endtask

   task automatic reset_seq();
      cyc_r(1'b1, 1'b0, rop(), rz(), e_if(1'b0));
      cyc_r(1'b1, 1'b1, rop(), rz(), e_if(1'b1));
   endtask

   task automatic fetch_decode(input logic [3:0] op, input int fw);
      for (int i = 0; i <= fw; i++) cyc(i == fw, rop(), rz(), e_if(i == fw));
      cyc(rz(), op, rz(), e_id());
   endtask

   task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input bit zb);
      fetch_decode(op, fw);
      if (is_mem(op))
         for (int i = 0; i <= mw; i++)
            cyc(i == mw, rop(), rz(), (op == 4'd5) ? e_mw() : e_mr(i == mw));
      if (is_ex(op)) cyc(rz(), rop(), rz(), e_ex(op));
      if (is_br(op)) cyc(rz(), rop(), zb, e_br(op, zb));
   endtask

   // Assert reset between clock edges and check it takes effect immediately.
   task automatic async_chk(input string name);
      #6 rst = 1'b1;
      #1;
      n_cmp++;
      if (state !== 3'd0 || mem_we !== 1'b0 || ld_acc !== 1'b0 || mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL %s: state=%0d mem_we=%b ld_acc=%b mem_req=%b, want 0/0/0/1",
                  name, state, mem_we, ld_acc, mem_req);
      end
   endtask

   task automatic main_seq();
      logic [3:0] legal[11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
      reset_seq();
      run_instr(4'd0, 0, 0, 1'b0);
      run_instr(4'd5, 0, 3, 1'b0);
      run_instr(4'd7, 1, 0, 1'b1);
      run_instr(4'd7, 0, 0, 1'b0);
      run_instr(4'd10, 0, 0, 1'b1);
      run_instr(4'd10, 2, 0, 1'b0);
      run_instr(4'd6, 0, 0, rz());
      run_instr(4'd4, 0, 2, 1'b0);
      run_instr(4'd3, 15, 0, 1'b0);
      run_instr(4'd1, 0, 15, 1'b0);
      for (int k = 0; k < 60; k++)
         run_instr(legal[$urandom_range(0, 10)], $urandom_range(0, 4),
                   $urandom_range(0, 4), rz());

      // Fetch never acknowledged: trap after TMO+1 cycles, then absorbing.
      for (int i = 0; i < 16; i++) cyc(1'b0, rop(), rz(), e_if(1'b0));
      for (int i = 0; i < 5; i++) cyc(rz(), rop(), rz(), e_trap());
      reset_seq();

      // Data read never acknowledged.
      fetch_decode(4'd9, 0);
      for (int i = 0; i < 16; i++) cyc(1'b0, rop(), rz(), e_mr(1'b0));
      for (int i = 0; i < 3; i++) cyc(rz(), rop(), rz(), e_trap());
      reset_seq();

      for (int op = 12; op < 16; op++) begin
         fetch_decode(4'(op), $urandom_range(0, 2));
         for (int i = 0; i < 3; i++) cyc(rz(), rop(), rz(), e_trap());
         reset_seq();
      end

      fetch_decode(4'd11, 0);
      for (int i = 0; i < 20; i++) cyc(rz(), rop(), rz(), e_halt());
      reset_seq();

      fetch_decode(4'd3, 0);
      cyc(rz(), rop(), rz(), e_ex(4'd3));
      async_chk("rst_mid_ex");
      reset_seq();

      fetch_decode(4'd5, 1);
      cyc(1'b0, rop(), rz(), e_mw());
      async_chk("rst_mid_sta");
      reset_seq();
      run_instr(4'd2, 0, 1, 1'b0);

      @(negedge clk); #1;
   endtask

   initial begin
      fork
         begin
            main_seq();
            done = 1'b1;
         end
         begin : monitor
            ov_t e;
            while (!done) begin
               @(negedge clk);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  n_cmp++;
                  if (act !== e) begin
                     n_bad++;
                     $display("FAIL trace t=%0t: act=%h exp=%h (state %0d vs %0d)",
                              $time, act, e, act.state, e.state);
                  end
               end
            end
         end
         begin : watchdog
            for (int i = 0; i < 60000 && !done; i++) @(posedge clk);
            if (!done) begin
               $display("FAIL watchdog: run did not complete within cycle budget");
               $fatal(1);
            end
         end
      join
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover: %0d expectations not compared, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
